// File: rtl/mod3_serial_tx.sv
// Serial MSB-first transmitter that appends a 2-bit check field so every
// (WIDTH+2)-bit frame value is a multiple of 3.
module mod3_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             tx_en,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_first,
  output logic             tx_last,
  output logic [1:0]       residue
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       residue_q, residue_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_first_q, tx_first_d;
  logic             tx_last_q, tx_last_d;
  logic             in_ready_q, in_ready_d;

  logic       adv;
  logic [2:0] res_sum;
  logic [1:0] res_nxt;
  logic [1:0] chk;

  // The presented bit always sits in the shift register MSB, so tx_bit is a flop.
  assign tx_bit   = shreg_q[WIDTH-1];
  assign tx_valid = tx_valid_q;
  assign tx_first = tx_first_q;
  assign tx_last  = tx_last_q;
  assign in_ready = in_ready_q;
  assign residue  = residue_q;

  always_comb begin
    adv     = tx_valid_q & tx_en;
    res_sum = {residue_q, 1'b0} + {2'b00, shreg_q[WIDTH-1]};
    res_nxt = (res_sum >= 3'd3) ? 2'(res_sum - 3'd3) : res_sum[1:0];
    case (res_nxt)
      2'd1:    chk = 2'b10;
      2'd2:    chk = 2'b01;
      default: chk = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    residue_d  = residue_q;
    tx_valid_d = tx_valid_q;
    tx_first_d = tx_first_q;
    tx_last_d  = tx_last_q;
    in_ready_d = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = DATA;
          shreg_d    = in_data;
          cnt_d      = '0;
          residue_d  = 2'd0;
          tx_valid_d = 1'b1;
          tx_first_d = 1'b1;
          tx_last_d  = 1'b0;
          in_ready_d = 1'b0;
        end
      end
      DATA: begin
        if (adv) begin
          residue_d  = res_nxt;
          tx_first_d = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d                = CHECK;
            shreg_d                = '0;
            shreg_d[WIDTH-1 -: 2]  = chk;
          end else begin
            shreg_d = shreg_q << 1;
          end
        end
      end
      CHECK: begin
        if (adv) begin
          residue_d = res_nxt;
          shreg_d   = shreg_q << 1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH)) begin
            tx_last_d = 1'b1;
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            in_ready_d = 1'b1;
            residue_d  = 2'd0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      residue_q  <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_first_q <= 1'b0;
      tx_last_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      residue_q  <= residue_d;
      tx_valid_q <= tx_valid_d;
      tx_first_q <= tx_first_d;
      tx_last_q  <= tx_last_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_mod3_serial_tx.sv
// Directed bench for mod3_serial_tx (WIDTH=8): frame bit patterns, flags,
// residue tracking, stalls, input hold-off and mid-frame reset.
module tb_mod3_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx_en;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_first;
  logic       tx_last;
  logic [1:0] residue;

  int checks = 0;
  int errors = 0;

  mod3_serial_tx #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_en(tx_en), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_first(tx_first), .tx_last(tx_last), .residue(residue)
  );

  always #5 clk = ~clk;

  // Collects one frame starting at a negedge where bit 0 is presented.
  // Stall mode drives tx_en 1,0,0,1,0,0,... and counts any output that moves while stalled.
  task automatic run_frame(input bit stall, output logic [9:0] bits,
                           output logic [9:0] firsts, output logic [9:0] lasts,
                           output logic [9:0][1:0] res, output int nen,
                           output int hold_bad, output int ready_bad);
    logic pb, pf;
    logic [1:0] pr;
    bit en;
    bits = '0; firsts = '0; lasts = '0; res = '0;
    nen = 0; hold_bad = 0; ready_bad = 0;
    for (int c = 0; c < 80 && nen < 10; c++) begin
      en    = stall ? (c % 3 == 0) : 1'b1;
      tx_en = en;
      if (tx_valid && en) begin
        bits[9-nen]   = tx_bit;
        firsts[9-nen] = tx_first;
        lasts[9-nen]  = tx_last;
        res[nen]      = residue;
        if (in_ready) ready_bad++;
        nen++;
      end
      pb = tx_bit; pf = tx_first; pr = residue;
      @(posedge clk); @(negedge clk);
      if (!en && (tx_bit !== pb || tx_first !== pf || residue !== pr || tx_valid !== 1'b1))
        hold_bad++;
    end
    tx_en = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d);
    in_data = d; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; tx_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_bit !== 1'b0) begin errors++; $display("FAIL reset_tx_bit got %b want 0", tx_bit); end
    checks++; if (tx_first !== 1'b0 || tx_last !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", tx_first, tx_last); end
    checks++; if (residue !== 2'd0) begin errors++; $display("FAIL reset_residue got %0d want 0", residue); end
  endtask

  task automatic test_frames;
    logic [7:0] din  [7] = '{8'h06, 8'h07, 8'h08, 8'hFF, 8'h00, 8'h03, 8'hA5};
    logic [9:0] dexp [7] = '{10'h018, 10'h01E, 10'h021, 10'h3FC, 10'h000, 10'h00C, 10'h294};
    logic [1:0] r8   [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [9:0] bits, firsts, lasts;
    logic [9:0][1:0] res;
    int nen, hb, rb;
    for (int i = 0; i < 7; i++) begin
      accept(din[i]);
      run_frame(1'b0, bits, firsts, lasts, res, nen, hb, rb);
      checks++; if (nen != 10) begin errors++; $display("FAIL frame%0d_len got %0d want 10", i, nen); end
      checks++; if (bits !== dexp[i]) begin errors++; $display("FAIL frame%0d_bits got %b want %b", i, bits, dexp[i]); end
      checks++; if (firsts !== 10'b1000000000) begin errors++; $display("FAIL frame%0d_first got %b want 1000000000", i, firsts); end
      checks++; if (lasts !== 10'b0000000001) begin errors++; $display("FAIL frame%0d_last got %b want 0000000001", i, lasts); end
      checks++; if (res[8] !== r8[i]) begin errors++; $display("FAIL frame%0d_res8 got %0d want %0d", i, res[8], r8[i]); end
      checks++; if (tx_valid !== 1'b0 || in_ready !== 1'b1 || residue !== 2'd0)
        begin errors++; $display("FAIL frame%0d_end got v%b r%b res%0d want v0 r1 res0", i, tx_valid, in_ready, residue); end
      if (din[i] == 8'h00) begin
        checks++; if (res !== '0) begin errors++; $display("FAIL zero_residue got %h want 0", res); end
      end
    end
  endtask

  task automatic test_stall;
    logic [9:0] bits, firsts, lasts;
    logic [9:0][1:0] res;
    int nen, hb, rb;
    accept(8'hA5);
    run_frame(1'b1, bits, firsts, lasts, res, nen, hb, rb);
    checks++; if (nen != 10) begin errors++; $display("FAIL stall_len got %0d want 10", nen); end
    checks++; if (bits !== 10'h294) begin errors++; $display("FAIL stall_bits got %b want 1010010100", bits); end
    checks++; if (hb != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", hb); end
    checks++; if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_end got v%b r%b want v0 r1", tx_valid, in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits, firsts, lasts;
    logic [9:0][1:0] res;
    int nen, hb, rb;
    in_data = 8'h07; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_data = 8'h3C;
    run_frame(1'b0, bits, firsts, lasts, res, nen, hb, rb);
    checks++; if (bits !== 10'h01E) begin errors++; $display("FAIL hold_bits got %b want 0000011110", bits); end
    checks++; if (rb != 0) begin errors++; $display("FAIL hold_ready got %0d busy cycles with in_ready want 0", rb); end
    checks++; if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_gap got v%b r%b want v0 r1", tx_valid, in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_first !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL hold_accept got v%b f%b r%b want v1 f1 r0", tx_valid, tx_first, in_ready); end
    run_frame(1'b0, bits, firsts, lasts, res, nen, hb, rb);
    checks++; if (bits !== 10'h0F0) begin errors++; $display("FAIL hold_second got %b want 0011110000", bits); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits, firsts, lasts;
    logic [9:0][1:0] res;
    int nen, hb, rb;
    accept(8'h55);
    tx_en = 1'b1;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    tx_en = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++; if (tx_valid !== 1'b0 || in_ready !== 1'b1 || residue !== 2'd0 || tx_bit !== 1'b0)
      begin errors++; $display("FAIL midreset got v%b r%b res%0d b%b want v1? no: v0 r1 res0 b0", tx_valid, in_ready, residue, tx_bit); end
    accept(8'h03);
    run_frame(1'b0, bits, firsts, lasts, res, nen, hb, rb);
    checks++; if (bits !== 10'h00C) begin errors++; $display("FAIL midreset_next got %b want 0000001100", bits); end
    checks++; if (firsts !== 10'b1000000000 || lasts !== 10'b0000000001)
      begin errors++; $display("FAIL midreset_flags got %b/%b want first/last at ends", firsts, lasts); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; tx_en = 1'b0;
    @(negedge clk);
    test_reset;
    test_frames;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
